// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock/calendar setting sequencer:
//   - state_e      : set-mode FSM states; the encoding doubles as field_sel.
//   - STB_*        : bit positions of the field-adjust strobes in a strobe vector.
//   - DEF_*        : default timing constants used as parameter defaults.
//   - next_field   : mode-button successor of a state.
//   - field_strobe : one-hot strobe vector owned by a SET state.
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN = 3'd0,
    ST_SEC = 3'd1,
    ST_MIN = 3'd2,
    ST_HR  = 3'd3,
    ST_DD  = 3'd4,
    ST_MM  = 3'd5,
    ST_YY  = 3'd6
  } state_e;

  localparam int NUM_STB = 6;
  localparam int STB_SC  = 0;
  localparam int STB_MN  = 1;
  localparam int STB_HRS = 2;
  localparam int STB_DT  = 3;
  localparam int STB_MON = 4;
  localparam int STB_YR  = 5;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_REPEAT_DELAY = 1000;
  localparam int DEF_REPEAT_RATE  = 250;
  localparam int DEF_TIMEOUT      = 30000;
  localparam int DEF_BLINK_HALF   = 500;

  // Fixed walk order of the mode button; YY wraps back to normal run.
  function automatic state_e next_field(input state_e s);
    case (s)
      ST_RUN:  return ST_SEC;
      ST_SEC:  return ST_MIN;
      ST_MIN:  return ST_HR;
      ST_HR:   return ST_DD;
      ST_DD:   return ST_MM;
      ST_MM:   return ST_YY;
      default: return ST_RUN;
    endcase
  endfunction

  // RUN (and the unused code 7) own no strobe.
  function automatic logic [NUM_STB-1:0] field_strobe(input state_e s);
    logic [NUM_STB-1:0] v;
    v = '0;
    case (s)
      ST_SEC:  v[STB_SC]  = 1'b1;
      ST_MIN:  v[STB_MN]  = 1'b1;
      ST_HR:   v[STB_HRS] = 1'b1;
      ST_DD:   v[STB_DT]  = 1'b1;
      ST_MM:   v[STB_MON] = 1'b1;
      ST_YY:   v[STB_YR]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_if
// Button inputs and display/counter-facing outputs of the setting sequencer.
//   mode_btn, inc_btn : raw asynchronous push-buttons, active-high.
//   sc/mn/hrs/dt/mon/yr : one-cycle field-adjust strobes to the counter.
//   field_sel : current state code (RUN=0 .. YY=6).
//   setting   : high whenever a field is selected.
//   blink     : blink phase for the selected field.
// master = button/panel side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface clock_set_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       sc;
  logic       mn;
  logic       hrs;
  logic       dt;
  logic       mon;
  logic       yr;
  logic [2:0] field_sel;
  logic       setting;
  logic       blink;

  modport master (
    output mode_btn, inc_btn,
    input  sc, mn, hrs, dt, mon, yr, field_sel, setting, blink
  );

  modport slave (
    input  mode_btn, inc_btn,
    output sc, mn, hrs, dt, mon, yr, field_sel, setting, blink
  );
endinterface

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings one asynchronous push-button into the clk domain and detects its
// rising edge.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_btn   : raw button, asynchronous
//   o_level : synchronized button level (last stage of the chain)
//   o_rise  : high for one cycle when o_level goes high
// -----------------------------------------------------------------------------
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of its neighbour and the chain shifts by exactly one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Set-mode sequencer for the clock/calendar counter. The mode button walks
// RUN -> SEC -> MIN -> HR -> DD -> MM -> YY -> RUN; the increment button fires
// the selected field's one-cycle strobe, with auto-repeat while held (all
// fields except SEC). Inactivity in a SET state returns to RUN.
//   clk  : system clock, rising edge
//   res  : asynchronous active-low reset
//   bus  : clock_set_ctrl_if.slave (buttons in; strobes, field_sel,
//          setting, blink out)
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input logic             clk,
  input logic             res,
  clock_set_ctrl_if.slave bus
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int BL_W    = $clog2(BLINK_HALF + 1);

  // Button conditioning. Mode only needs its edge.
  logic w_mode_level_unused;
  logic w_mode_rise;
  logic w_inc_level;
  logic w_inc_rise;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk     (clk),
    .rst_n   (res),
    .i_btn   (bus.mode_btn),
    .o_level (w_mode_level_unused),
    .o_rise  (w_mode_rise)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
    .clk     (clk),
    .rst_n   (res),
    .i_btn   (bus.inc_btn),
    .o_level (w_inc_level),
    .o_rise  (w_inc_rise)
  );

  state_e             r_state,     w_state_next;
  logic [NUM_STB-1:0] r_stb,       w_stb_next;
  logic [REP_W-1:0]   r_rep_cnt,   w_rep_cnt_next;
  logic               r_rep_fast,  w_rep_fast_next;
  logic [TO_W-1:0]    r_to_cnt,    w_to_cnt_next;
  logic [BL_W-1:0]    r_blink_cnt, w_blink_cnt_next;
  logic               r_blink,     w_blink_next;

  logic             w_set;
  logic             w_rep_fire;
  logic             w_timeout;
  logic [REP_W-1:0] w_rep_thr;

  assign w_set     = (r_state != ST_RUN);
  assign w_rep_thr = r_rep_fast ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= ST_RUN;
      r_stb       <= '0;
      r_rep_cnt   <= '0;
      r_rep_fast  <= 1'b0;
      r_to_cnt    <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stb       <= w_stb_next;
      r_rep_cnt   <= w_rep_cnt_next;
      r_rep_fast  <= w_rep_fast_next;
      r_to_cnt    <= w_to_cnt_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_blink     <= w_blink_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    w_state_next     = r_state;
    w_stb_next       = '0;
    w_rep_cnt_next   = '0;
    w_rep_fast_next  = 1'b0;
    w_to_cnt_next    = '0;
    w_blink_cnt_next = '0;
    w_blink_next     = 1'b0;
    w_rep_fire       = 1'b0;
    w_timeout        = 1'b0;

    // Auto-repeat. A zero count means "not armed"; only a fresh inc edge in a
    // repeating field arms it, so a mode edge or release stops it for good.
    if (w_set && !w_mode_rise && w_inc_level) begin
      if (w_inc_rise) begin
        w_rep_cnt_next = (r_state == ST_SEC) ? '0 : REP_W'(1);
      end else if (r_rep_cnt != '0) begin
        if (r_rep_cnt == w_rep_thr) begin
          w_rep_fire      = 1'b1;
          w_rep_cnt_next  = REP_W'(1);
          w_rep_fast_next = 1'b1;
        end else begin
          w_rep_cnt_next  = r_rep_cnt + 1'b1;
          w_rep_fast_next = r_rep_fast;
        end
      end
    end

    // Inactivity timeout; any user activity restarts it.
    if (w_set) begin
      if (w_mode_rise || w_inc_rise || w_rep_fire) begin
        w_to_cnt_next = '0;
      end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
        w_timeout = 1'b1;
      end else begin
        w_to_cnt_next = r_to_cnt + 1'b1;
      end
    end

    // Mode wins over a coincident inc edge: advance and emit nothing.
    if (w_mode_rise) begin
      w_state_next = next_field(r_state);
    end else if (w_timeout) begin
      w_state_next = ST_RUN;
    end else if (w_set && (w_inc_rise || w_rep_fire)) begin
      w_stb_next = field_strobe(r_state);
    end

    // Blink restarts low on any state change and is held off in RUN.
    if (w_set && (w_state_next == r_state)) begin
      if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
        w_blink_next = ~r_blink;
      end else begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
        w_blink_next     = r_blink;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.sc        = r_stb[STB_SC];
    bus.mn        = r_stb[STB_MN];
    bus.hrs       = r_stb[STB_HRS];
    bus.dt        = r_stb[STB_DT];
    bus.mon       = r_stb[STB_MON];
    bus.yr        = r_stb[STB_YR];
    bus.field_sel = r_state;
    bus.setting   = w_set;
    bus.blink     = r_blink;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl with REPEAT_DELAY=8, REPEAT_RATE=4,
// TIMEOUT=50, BLINK_HALF=5. Inputs change and outputs are sampled on the
// falling clock edge; cycle offsets below count falling edges after the
// input change.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  logic clk;
  logic res;

  clock_set_ctrl_if bus_if ();

  clock_set_ctrl #(
    .SYNC_STAGES  (2),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4),
    .TIMEOUT      (50),
    .BLINK_HALF   (5)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector bit order: sc, mn, hrs, dt, mon, yr
  localparam int B_SC = 0, B_MN = 1, B_HRS = 2, B_DT = 3, B_MON = 4, B_YR = 5;

  int         n_vec;
  int         n_err;
  logic [5:0] s_stb;
  int         str_cnt [6];
  int         max_ones;

  function automatic int total_strobes();
    int t;
    t = 0;
    for (int i = 0; i < 6; i++) t += str_cnt[i];
    return t;
  endfunction

  task automatic clr();
    for (int i = 0; i < 6; i++) str_cnt[i] = 0;
    max_ones = 0;
  endtask

  // One falling edge: sample the strobes and keep per-strobe counts.
  task automatic cyc();
    @(negedge clk);
    s_stb = {bus_if.yr, bus_if.mon, bus_if.dt, bus_if.hrs, bus_if.mn, bus_if.sc};
    for (int i = 0; i < 6; i++) if (s_stb[i] === 1'b1) str_cnt[i]++;
    if ($countones(s_stb) > max_ones) max_ones = $countones(s_stb);
  endtask

  // Mode press held 3 cycles; the state has advanced by the third edge.
  task automatic press_mode();
    bus_if.mode_btn = 1'b1;
    repeat (3) cyc();
    bus_if.mode_btn = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    res = 1'b0;
    bus_if.mode_btn = 1'b0;
    bus_if.inc_btn  = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if ({s_stb, bus_if.field_sel, bus_if.setting, bus_if.blink} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %0h expected 0",
               {s_stb, bus_if.field_sel, bus_if.setting, bus_if.blink});
    end
    res = 1'b1;
    clr();
    repeat (5) cyc();
    n_vec++;
    if ({bus_if.field_sel, bus_if.setting, bus_if.blink} !== 5'h0 || total_strobes() != 0) begin
      n_err++;
      $display("FAIL reset_release: got sel=%0d set=%0b blink=%0b strobes=%0d expected 0 0 0 0",
               bus_if.field_sel, bus_if.setting, bus_if.blink, total_strobes());
    end
  endtask

  task automatic test_mode_walk();
    clr();
    for (int i = 1; i <= 3; i++) begin
      press_mode();
      n_vec++;
      if (bus_if.field_sel !== 3'(i) || bus_if.setting !== 1'b1) begin
        n_err++;
        $display("FAIL walk_sel%0d: got sel=%0d set=%0b expected sel=%0d set=1",
                 i, bus_if.field_sel, bus_if.setting, i);
      end
    end
    n_vec++;
    if (total_strobes() != 0) begin
      n_err++;
      $display("FAIL walk_strobes: got %0d expected 0", total_strobes());
    end
  endtask

  // HR: edge strobe at offset 3, repeats at 11, 15, 19; release stops it.
  task automatic test_repeat_hr();
    int pos[$];
    int exp_pos[4];
    exp_pos = '{3, 11, 15, 19};
    clr();
    bus_if.inc_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (s_stb[B_HRS] === 1'b1) pos.push_back(k);
      if (k == 20) bus_if.inc_btn = 1'b0;
    end
    n_vec++;
    if (pos.size() != 4) begin
      n_err++;
      $display("FAIL repeat_count: got %0d expected 4", pos.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < pos.size()) begin
        n_vec++;
        if (pos[i] != exp_pos[i]) begin
          n_err++;
          $display("FAIL repeat_pos%0d: got %0d expected %0d", i, pos[i], exp_pos[i]);
        end
      end
    end
    n_vec++;
    if (total_strobes() != str_cnt[B_HRS] || max_ones > 1) begin
      n_err++;
      $display("FAIL repeat_other: got other=%0d max_ones=%0d expected 0 1",
               total_strobes() - str_cnt[B_HRS], max_ones);
    end
  endtask

  task automatic test_mode_inc_same();
    press_mode();
    n_vec++;
    if (bus_if.field_sel !== 3'd4) begin
      n_err++;
      $display("FAIL same_enter_dd: got %0d expected 4", bus_if.field_sel);
    end
    clr();
    bus_if.mode_btn = 1'b1;
    bus_if.inc_btn  = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k == 3)  bus_if.mode_btn = 1'b0;
      if (k == 15) bus_if.inc_btn  = 1'b0;
    end
    repeat (3) cyc();
    n_vec++;
    if (bus_if.field_sel !== 3'd5) begin
      n_err++;
      $display("FAIL same_sel: got %0d expected 5", bus_if.field_sel);
    end
    n_vec++;
    if (str_cnt[B_DT] != 0 || str_cnt[B_MON] != 0 || total_strobes() != 0) begin
      n_err++;
      $display("FAIL same_strobes: got dt=%0d mon=%0d total=%0d expected 0 0 0",
               str_cnt[B_DT], str_cnt[B_MON], total_strobes());
    end
  endtask

  task automatic test_timeout_blink();
    int   waited;
    logic exp_blink;
    bus_if.mode_btn = 1'b1;
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (bus_if.field_sel !== 3'd6 && waited < 10);
    bus_if.mode_btn = 1'b0;
    n_vec++;
    if (bus_if.field_sel !== 3'd6) begin
      n_err++;
      $display("FAIL tmo_enter_yy: got %0d expected 6", bus_if.field_sel);
    end
    clr();
    for (int j = 0; j < 50; j++) begin
      exp_blink = ((j / 5) % 2) == 1;
      n_vec++;
      if (bus_if.field_sel !== 3'd6 || bus_if.blink !== exp_blink) begin
        n_err++;
        $display("FAIL blink_j%0d: got sel=%0d blink=%0b expected sel=6 blink=%0b",
                 j, bus_if.field_sel, bus_if.blink, exp_blink);
      end
      cyc();
    end
    n_vec++;
    if ({bus_if.field_sel, bus_if.setting, bus_if.blink} !== 5'h0 || total_strobes() != 0) begin
      n_err++;
      $display("FAIL timeout_run: got sel=%0d set=%0b blink=%0b strobes=%0d expected 0 0 0 0",
               bus_if.field_sel, bus_if.setting, bus_if.blink, total_strobes());
    end
  endtask

  task automatic test_run_ignored();
    clr();
    bus_if.inc_btn = 1'b1;
    repeat (14) cyc();
    bus_if.inc_btn = 1'b0;
    repeat (4) cyc();
    n_vec++;
    if (total_strobes() != 0 || bus_if.field_sel !== 3'd0 || bus_if.setting !== 1'b0) begin
      n_err++;
      $display("FAIL run_ignored: got strobes=%0d sel=%0d set=%0b expected 0 0 0",
               total_strobes(), bus_if.field_sel, bus_if.setting);
    end
  endtask

  task automatic test_sec_no_repeat();
    press_mode();
    n_vec++;
    if (bus_if.field_sel !== 3'd1) begin
      n_err++;
      $display("FAIL sec_enter: got %0d expected 1", bus_if.field_sel);
    end
    clr();
    bus_if.inc_btn = 1'b1;
    repeat (30) cyc();
    bus_if.inc_btn = 1'b0;
    repeat (5) cyc();
    n_vec++;
    if (str_cnt[B_SC] != 1 || total_strobes() != 1 || max_ones > 1) begin
      n_err++;
      $display("FAIL sec_single: got sc=%0d total=%0d expected 1 1",
               str_cnt[B_SC], total_strobes());
    end
  endtask

  task automatic test_single_press();
    int first;
    press_mode();
    n_vec++;
    if (bus_if.field_sel !== 3'd2) begin
      n_err++;
      $display("FAIL min_enter: got %0d expected 2", bus_if.field_sel);
    end
    clr();
    first = -1;
    bus_if.inc_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 2) bus_if.inc_btn = 1'b0;
      if (s_stb[B_MN] === 1'b1 && first < 0) first = k;
    end
    n_vec++;
    if (first != 3) begin
      n_err++;
      $display("FAIL mn_latency: got %0d expected 3", first);
    end
    n_vec++;
    if (str_cnt[B_MN] != 1 || total_strobes() != 1) begin
      n_err++;
      $display("FAIL mn_width: got mn=%0d total=%0d expected 1 1",
               str_cnt[B_MN], total_strobes());
    end
  endtask

  // In MIN: hold inc, press mode after the first strobe; repeat must stop.
  task automatic test_mode_while_held();
    clr();
    bus_if.inc_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (k == 5) bus_if.mode_btn = 1'b1;
      if (k == 8) bus_if.mode_btn = 1'b0;
    end
    bus_if.inc_btn = 1'b0;
    repeat (4) cyc();
    n_vec++;
    if (str_cnt[B_MN] != 1 || str_cnt[B_HRS] != 0 || bus_if.field_sel !== 3'd3) begin
      n_err++;
      $display("FAIL held_mode: got mn=%0d hrs=%0d sel=%0d expected 1 0 3",
               str_cnt[B_MN], str_cnt[B_HRS], bus_if.field_sel);
    end
  endtask

  task automatic test_reset_mid_repeat();
    press_mode();
    press_mode();
    n_vec++;
    if (bus_if.field_sel !== 3'd5) begin
      n_err++;
      $display("FAIL mm_enter: got %0d expected 5", bus_if.field_sel);
    end
    clr();
    bus_if.inc_btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 3 || k == 11) begin
        n_vec++;
        if (s_stb !== 6'b010000) begin
          n_err++;
          $display("FAIL mm_strobe_k%0d: got %0b expected 010000", k, s_stb);
        end
      end
    end
    #1 res = 1'b0;
    #1;
    n_vec++;
    if ({bus_if.yr, bus_if.mon, bus_if.dt, bus_if.hrs, bus_if.mn, bus_if.sc,
         bus_if.field_sel, bus_if.setting, bus_if.blink} !== 11'h0) begin
      n_err++;
      $display("FAIL async_reset: got %0h expected 0",
               {bus_if.yr, bus_if.mon, bus_if.dt, bus_if.hrs, bus_if.mn, bus_if.sc,
                bus_if.field_sel, bus_if.setting, bus_if.blink});
    end
    repeat (2) cyc();
    res = 1'b1;
    clr();
    repeat (20) cyc();
    bus_if.inc_btn = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if (total_strobes() != 0 || bus_if.field_sel !== 3'd0 || bus_if.setting !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset: got strobes=%0d sel=%0d set=%0b expected 0 0 0",
               total_strobes(), bus_if.field_sel, bus_if.setting);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    s_stb = '0;
    clr();
    res = 1'b0;
    bus_if.mode_btn = 1'b0;
    bus_if.inc_btn  = 1'b0;
    test_reset();
    test_mode_walk();
    test_repeat_hr();
    test_mode_inc_same();
    test_timeout_blink();
    test_run_ignored();
    test_sec_no_repeat();
    test_single_press();
    test_mode_while_held();
    test_reset_mid_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- User-interface sequencer for the `digital` clock/calendar counter.
- Turns two raw push-buttons (mode, increment) into the single-cycle field-adjust strobes `sc`, `mn`, `hrs`, `dt`, `mon`, `yr` that drive `digital`.
- A set-mode FSM selects one field at a time, with auto-repeat on a held increment and an inactivity timeout back to normal run.
- Also provides field-select and blink indicators for the display driver.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per button input (min 2).
- REPEAT_DELAY, 1000, cycles inc must stay held after its edge before the first auto-repeat strobe.
- REPEAT_RATE, 250, cycles between subsequent auto-repeat strobes.
- TIMEOUT, 30000, idle cycles in a SET state before forced return to RUN.
- BLINK_HALF, 500, cycles per half-period of the blink output.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- mode_btn  in  1  raw mode button, asynchronous, active-high.
- inc_btn  in  1  raw increment button, asynchronous, active-high.
- sc  out  1  one-cycle strobe, clear seconds.
- mn  out  1  one-cycle strobe, minute +1.
- hrs  out  1  one-cycle strobe, hour +1.
- dt  out  1  one-cycle strobe, day +1.
- mon  out  1  one-cycle strobe, month +1.
- yr  out  1  one-cycle strobe, year +1.
- field_sel  out  3  current state code (RUN=0, SEC=1, MIN=2, HR=3, DD=4, MM=5, YY=6).
- setting  out  1  high whenever state != RUN.
- blink  out  1  display blink phase for the selected field.

Behaviour:
- Reset (res=0, asynchronous): state RUN, all strobes 0, field_sel 0, setting 0, blink 0; sync/edge flops, repeat, timeout and blink counters all 0. Release is sampled on clk.
- Input path: each button passes through a SYNC_STAGES flop chain, then an edge register.
  - A rising edge is the synchronized value high while the edge-reg value is low.
  - Strobes are registered. A button first sampled high at edge k gives its strobe high for the cycle following edge k+SYNC_STAGES (3 edges at default).
- FSM: RUN -> SEC -> MIN -> HR -> DD -> MM -> YY -> RUN, advancing one step per mode edge. No other transitions except timeout and reset.
- Inc edge in a SET state: one-cycle strobe on that state's output (SEC->sc, MIN->mn, HR->hrs, DD->dt, MM->mon, YY->yr).
- Inc in RUN is ignored; no strobes are ever generated in RUN.
- Auto-repeat (all SET states except SEC):
  - While inc stays synchronized-high after its edge, the repeat counter counts.
  - On reaching REPEAT_DELAY it emits a strobe, reloads, and then emits one strobe every REPEAT_RATE cycles.
  - Inc release clears the counter immediately, so no trailing strobe.
- Simultaneous mode edge and inc edge: mode wins. State advances, no strobe, repeat counter cleared.
- Mode edge while inc held: repeat stops; it resumes only after a fresh inc edge.
- Timeout counter:
  - Runs only in SET states; cleared by any mode or inc edge, by an auto-repeat strobe, and on entry to RUN.
  - On reaching TIMEOUT-1: state becomes RUN next cycle, no strobe.
  - A timeout in the same cycle as an edge is not possible, because the edge clears the counter first.
- Mutual exclusion: at most one of sc/mn/hrs/dt/mon/yr is high in any cycle. Each strobe is exactly one cycle wide.
- blink:
  - Toggles every BLINK_HALF cycles while setting=1.
  - Forced 0 and counter cleared in RUN.
  - Restarts low with counter 0 on every state change.
- Counter widths: $clog2(param+1); no counter may wrap.
- Reset asserted mid-repeat or mid-set: all outputs drop asynchronously. The strobe in flight is lost.

Decomposition:
- Shared package `clock_pkg`: state enum/localparams (RUN..YY, 3-bit), strobe index constants, default timing constants.
- One sub-module `btn_sync_edge` (SYNC_STAGES param; outputs level and rise pulse), instantiated twice.
- FSM, repeat, timeout and blink logic live in the top.

Test Plan:
- Use REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=50, BLINK_HALF=5 throughout.
- Reset then 3 mode presses -> field_sel 1,2,3; setting=1; no strobes emitted.
- In MIN, one 2-cycle inc press -> mn high exactly 1 cycle, 3 edges after press; no other strobes.
- In HR, inc held 20 cycles after its edge -> hrs strobes at edge+0, +8, +12, +16 (4 total); release -> none further.
- In SEC, inc held 30 cycles -> exactly one sc strobe (no repeat).
- mode and inc raised in the same cycle in DD -> field_sel 5, dt/mon never high.
- In YY, idle 50 cycles -> field_sel 0, setting 0, blink 0; blink toggled every 5 cycles before that.
- Reset asserted while inc held in MM -> all outputs 0 immediately; after release, state RUN and no mon strobe.
